// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HAVE    = 2'd1,
        DISCARD = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous reset, redirect load and increment.
module if_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_target,
    input  logic        i_inc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus_one
);

    logic [31:0] r_pc;

    // Load takes priority so a redirect wins over a same-cycle delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + 32'd1;
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus_one = r_pc + 32'd1;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// drives the IF/ID hold/flush controls. Define IF_PERF_EN to add perf counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instrOut,
    output logic [31:0] PCPlusOne,
    output logic        ifidHold,
    output logic        ifidFlush
`ifdef IF_PERF_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount
`endif
);

    if_state_t   r_state;
    logic [31:0] r_buf;

    if_state_t   w_next;
    logic        w_req;
    logic        w_hold;
    logic        w_flush;
    logic [31:0] w_instr;
    logic        w_deliver;
    logic        w_buf_load;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus_one;

    if_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .i_load       (redirect),
        .i_target     (redirectPC),
        .i_inc        (w_deliver),
        .o_pc         (w_pc),
        .o_pc_plus_one(w_pc_plus_one)
    );

    always_comb begin
        w_req      = 1'b0;
        w_hold     = 1'b1;
        w_flush    = 1'b1;
        w_instr    = NOP_INSTR;
        w_deliver  = 1'b0;
        w_buf_load = 1'b0;
        w_next     = r_state;
        if (!rst) begin
            unique case (r_state)
                FETCH: begin
                    w_req = 1'b1;
                    if (imemAck && !hold) begin
                        w_instr   = imemData;
                        w_hold    = 1'b0;
                        w_deliver = 1'b1;
                    end else if (imemAck) begin
                        w_flush    = 1'b0;
                        w_buf_load = 1'b1;
                        w_next     = HAVE;
                    end else begin
                        w_flush = !hold;
                    end
                end
                HAVE: begin
                    w_instr = r_buf;
                    if (!hold) begin
                        w_hold    = 1'b0;
                        w_deliver = 1'b1;
                        w_next    = FETCH;
                    end else begin
                        w_flush = 1'b0;
                    end
                end
                DISCARD: begin
                    w_flush = !hold;
                    if (imemAck) begin
                        w_next = FETCH;
                    end
                end
                default: w_next = FETCH;
            endcase
            // A redirect squashes everything; while a request is still in
            // flight its stale ack must be swallowed in DISCARD.
            if (redirect) begin
                w_hold     = 1'b1;
                w_flush    = 1'b1;
                w_instr    = NOP_INSTR;
                w_deliver  = 1'b0;
                w_buf_load = 1'b0;
                w_next     = (r_state != HAVE && !imemAck) ? DISCARD : FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_buf   <= NOP_INSTR;
        end else begin
            r_state <= w_next;
            if (redirect) begin
                r_buf <= NOP_INSTR;
            end else if (w_buf_load) begin
                r_buf <= imemData;
            end
        end
    end

    assign imemReq   = w_req;
    assign imemAddr  = w_pc;
    assign instrOut  = w_instr;
    assign PCPlusOne = w_pc_plus_one;
    assign ifidHold  = w_hold;
    assign ifidFlush = w_flush;

`ifdef IF_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_deliver) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_hold) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetchCount = r_fetch_cnt;
    assign stallCount = r_stall_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with RESET_PC = 32'h100.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instrOut;
    logic [31:0] PCPlusOne;
    logic        ifidHold;
    logic        ifidFlush;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_unit #(
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .redirect  (redirect),
        .redirectPC(redirectPC),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemData  (imemData),
        .instrOut  (instrOut),
        .PCPlusOne (PCPlusOne),
        .ifidHold  (ifidHold),
        .ifidFlush (ifidFlush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then sample combinational outputs 1ns later.
    task automatic drive(input logic r, input logic h, input logic rd, input logic [31:0] rpc,
                         input logic ack, input logic [31:0] data);
        @(negedge clk);
        rst        = r;
        hold       = h;
        redirect   = rd;
        redirectPC = rpc;
        imemAck    = ack;
        imemData   = data;
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic hld, input logic fl);
        chk({tag, ".req"},   32'(imemReq),   32'(req));
        chk({tag, ".hold"},  32'(ifidHold),  32'(hld));
        chk({tag, ".flush"}, 32'(ifidFlush), 32'(fl));
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirectPC = 32'h0;
        imemAck = 1'b0; imemData = 32'h0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("rst", 1'b0, 1'b1, 1'b1);
        chk("rst.instr", instrOut, 32'h0);
        chk("rst.addr",  imemAddr, 32'h100);

        // Zero-wait memory: one instruction per cycle
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0100);
        chk("zw0.addr", imemAddr, 32'h100);
        chk("zw0.pc1",  PCPlusOne, 32'h101);
        chk_ctl("zw0", 1'b1, 1'b0, ifidFlush);
        chk("zw0.instr", instrOut, 32'hA000_0100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0101);
        chk("zw1.addr", imemAddr, 32'h101);
        chk("zw1.pc1",  PCPlusOne, 32'h102);
        chk("zw1.hold", 32'(ifidHold), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0102);
        chk("zw2.addr", imemAddr, 32'h102);
        chk("zw2.pc1",  PCPlusOne, 32'h103);
        chk("zw2.hold", 32'(ifidHold), 32'd0);

        // Two-cycle wait memory at PC 103
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("w1", 1'b1, 1'b1, 1'b1);
        chk("w1.addr", imemAddr, 32'h103);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("w2", 1'b1, 1'b1, 1'b1);
        chk("w2.addr", imemAddr, 32'h103);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0103);
        chk("w3.hold",  32'(ifidHold), 32'd0);
        chk("w3.instr", instrOut, 32'hB000_0103);
        chk("w3.pc1",   PCPlusOne, 32'h104);

        // ack together with hold, hold kept for three cycles
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC000_0104);
        chk_ctl("h1", 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("h2", 1'b0, 1'b1, 1'b0);
        chk("h2.addr", imemAddr, 32'h104);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("h3", 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("h4.hold",  32'(ifidHold), 32'd0);
        chk("h4.instr", instrOut, 32'hC000_0104);
        chk("h4.pc1",   PCPlusOne, 32'h105);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("h5.addr", imemAddr, 32'h105);
        chk("h5.req",  32'(imemReq), 32'd1);

        // Redirect while a request is outstanding; the stale ack is dropped
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
        chk_ctl("rd1", 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk_ctl("rd2", 1'b0, 1'b1, 1'b1);
        chk("rd2.instr", instrOut, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hE000_0200);
        chk("rd3.addr",  imemAddr, 32'h200);
        chk("rd3.req",   32'(imemReq), 32'd1);
        chk("rd3.hold",  32'(ifidHold), 32'd0);
        chk("rd3.instr", instrOut, 32'hE000_0200);

        // Redirect in the same cycle as ack squashes the acked instruction
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'hF000_0201);
        chk_ctl("ra1", 1'b1, 1'b1, 1'b1);
        chk("ra1.instr", instrOut, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF000_0200);
        chk("ra2.addr",  imemAddr, 32'h200);
        chk("ra2.hold",  32'(ifidHold), 32'd0);
        chk("ra2.pc1",   PCPlusOne, 32'h201);
        chk("ra2.instr", instrOut, 32'hF000_0200);

        // PC wrap at 32'hFFFF_FFFF
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        chk("wr1.addr", imemAddr, 32'hFFFF_FFFF);
        chk("wr1.pc1",  PCPlusOne, 32'h0);
        chk("wr1.hold", 32'(ifidHold), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wr2.addr", imemAddr, 32'h0);
        chk("wr2.pc1",  PCPlusOne, 32'h1);

        // Reset mid-transaction abandons the request
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("mr1", 1'b0, 1'b1, 1'b1);
        chk("mr1.instr", instrOut, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("mr2.addr", imemAddr, 32'h100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_ctl("mr3", 1'b1, 1'b1, 1'b1);
        chk("mr3.addr", imemAddr, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, issues word-addressed requests to instruction memory over a req/ack handshake and delivers instructions with their PC+1. It drives the load/hold/flush controls of the IF/ID pipeline register, inserting bubbles on memory wait and on branch/jump redirects, and freezing IF/ID on decode stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  decode-stage stall from the hazard unit; IF/ID must keep its contents.
- redirect  in  1  branch/jump taken, resolved in ID.
- redirectPC  in  32  target PC, valid with redirect.
- imemReq  out  1  instruction memory request.
- imemAddr  out  32  word address; equals PC.
- imemAck  in  1  one-cycle pulse; imemData valid the same cycle.
- imemData  in  32  fetched instruction.
- instrOut  out  32  to IF/ID instrIn.
- PCPlusOne  out  32  to IF/ID PCPlusOne; PC+1 of the delivered instruction.
- ifidHold  out  1  to IF/ID hold.
- ifidFlush  out  1  to IF/ID IF_flush.

## Operation
- IF/ID semantics: hold=0 loads; hold=1, flush=1 loads a bubble (instr 0); hold=1, flush=0 keeps.
- States: FETCH (request outstanding), HAVE (instruction buffered, waiting for hold release), DISCARD (redirected while a request is outstanding; awaiting the stale ack).
- FETCH: imemReq=1, imemAddr=PC.
  - ack, !hold: instrOut=imemData, ifidHold=0, PC<=PC+1, stay in FETCH.
  - ack, hold: buffer imemData, ifidHold=1, ifidFlush=0, go to HAVE.
  - no ack: ifidHold=1, ifidFlush=!hold.
- HAVE: imemReq=0, instrOut=buffer. On !hold: ifidHold=0, PC<=PC+1, go to FETCH. On hold: ifidHold=1, ifidFlush=0.
- DISCARD: imemReq=0, ifidHold=1, ifidFlush=!hold. On ack: drop the data and go to FETCH.
- redirect has priority over all of the above:
  - PC<=redirectPC, ifidHold=1, ifidFlush=1, buffer discarded.
  - Next state is DISCARD if in FETCH without ack this cycle, else FETCH.
- PCPlusOne = PC+1, modulo 2^32; PC=32'hFFFF_FFFF wraps to 0.
- imemAddr and PC must stay stable while imemReq=1 and no ack has arrived.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, buffer=0.
- While rst=1: imemReq=0, ifidHold=1, ifidFlush=1, instrOut=0.
- Reset mid-transaction abandons the request. Instruction memory shares rst and issues no ack for a pre-reset request.
- First request is in the cycle after rst deasserts.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, written to IF/ID on the ack edge.
- N-wait memory: N bubbles into IF/ID, unless hold is asserted.
- hold and ack arriving together: no instruction lost; it is delivered on the first cycle with hold=0.
- A redirect in the same cycle as ack squashes the acked instruction.

## Configuration
- IF_PERF_EN defined: adds outputs fetchCount and stallCount (32-bit each, reset 0, wrapping).
  - fetchCount increments per instruction delivered with ifidHold=0.
  - stallCount increments per cycle with ifidHold=1 outside reset.
- IF_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package if_pkg: state enum (FETCH, HAVE, DISCARD) and constant NOP_INSTR=32'h0.
- Sub-module if_pc_reg is natural: the PC register with synchronous reset, load-target and increment controls.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory -> imemAddr sequence 100,101,102; PCPlusOne 101,102,103; ifidHold=0 every cycle.
- Memory with 2-cycle wait -> two cycles of ifidHold=1, ifidFlush=1, then delivery with ifidHold=0.
- ack together with hold=1 for 3 cycles -> ifidFlush=0 throughout; the buffered instruction is delivered on hold release; PC advances exactly once.
- redirect to 32'h200 while a request is outstanding -> ifidFlush=1 pulse, stale ack dropped, next imemAddr=200.
- redirect in the same cycle as ack -> acked instruction not delivered; next delivered PCPlusOne=201.
- PC=32'hFFFF_FFFF -> PCPlusOne=0 and next imemAddr=0.
